// File: rtl/icache_param.sv
// Direct-mapped instruction cache with word-by-word block fill, whole-cache flush
// and a running count of fills started.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage

module icache_param
    import cpu_types_pkg::*;
#(
    parameter int NSETS       = 16,
    parameter int BLOCK_WORDS = 2
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    input  logic  iflush,
    output logic  iREN,
    output word_t iaddr,
    input  word_t iload,
    input  logic  iwait,
    output word_t miss_count
);

    localparam int OFF_W   = $clog2(BLOCK_WORDS);
    localparam int IDX_W   = $clog2(NSETS);
    localparam int CNT_W   = (OFF_W > 0) ? OFF_W : 1;
    localparam int TAG_W   = 30 - OFF_W - IDX_W;
    localparam int PTR_W   = IDX_W + OFF_W;
    localparam int IDX_LSB = 2 + OFF_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 next_s;
    logic [NSETS-1:0]       valid_r;
    logic [TAG_W-1:0]       tag_mem_r  [NSETS];
    word_t                  data_mem_r [2**PTR_W];
    logic [TAG_W-1:0]       fill_tag_r;
    logic [IDX_W-1:0]       fill_idx_r;
    logic [CNT_W-1:0]       cnt_r;
    word_t                  miss_count_r;

    logic [TAG_W-1:0]       req_tag_s;
    logic [IDX_W-1:0]       req_idx_s;
    logic [CNT_W-1:0]       req_off_s;
    logic                   tag_match_s;
    logic                   start_fill_s;
    logic                   word_we_s;
    logic                   fill_done_s;
    logic                   flush_all_s;

    function automatic logic [IDX_W-1:0] addr_idx(input word_t a);
        word_t s;
        s = a >> IDX_LSB;
        return s[IDX_W-1:0];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input word_t a);
        word_t s;
        s = a >> TAG_LSB;
        return s[TAG_W-1:0];
    endfunction

    // Word offset collapses to constant 0 when a line holds a single word.
    function automatic logic [CNT_W-1:0] addr_off(input word_t a);
        word_t s;
        s = (a >> 2) & word_t'(BLOCK_WORDS - 1);
        return s[CNT_W-1:0];
    endfunction

    function automatic logic [PTR_W-1:0] data_ptr(input logic [IDX_W-1:0] idx,
                                                  input logic [CNT_W-1:0] off);
        word_t p;
        p = (word_t'(idx) << OFF_W) | (word_t'(off) & word_t'(BLOCK_WORDS - 1));
        return p[PTR_W-1:0];
    endfunction

    assign req_tag_s   = addr_tag(imemaddr);
    assign req_idx_s   = addr_idx(imemaddr);
    assign req_off_s   = addr_off(imemaddr);
    assign tag_match_s = valid_r[req_idx_s] && (tag_mem_r[req_idx_s] == req_tag_s);
    assign miss_count  = miss_count_r;

    // Next-state and fetch/memory-side outputs.
    always_comb begin
        next_s       = state_r;
        ihit         = 1'b0;
        imemload     = 32'h0000_0000;
        iREN         = 1'b0;
        iaddr        = 32'h0000_0000;
        start_fill_s = 1'b0;
        word_we_s    = 1'b0;
        fill_done_s  = 1'b0;
        flush_all_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (iflush) begin
                    flush_all_s = 1'b1;
                end else if (imemREN) begin
                    if (tag_match_s) begin
                        ihit     = 1'b1;
                        imemload = data_mem_r[data_ptr(req_idx_s, req_off_s)];
                    end else begin
                        start_fill_s = 1'b1;
                        next_s       = FILL;
                    end
                end else begin
                    next_s = IDLE;
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = (word_t'(fill_tag_r) << TAG_LSB)
                      | (word_t'(fill_idx_r) << IDX_LSB)
                      | ((word_t'(cnt_r) & word_t'(BLOCK_WORDS - 1)) << 2);
                if (iflush) begin
                    // Abort: the word on the bus this cycle is dropped.
                    flush_all_s = 1'b1;
                    next_s      = IDLE;
                end else if (!iwait) begin
                    word_we_s = 1'b1;
                    if (cnt_r == LAST_WORD) begin
                        fill_done_s = 1'b1;
                        next_s      = IDLE;
                    end else begin
                        next_s = FILL;
                    end
                end else begin
                    next_s = FILL;
                end
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Latched fill target, word counter and miss counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fill_tag_r   <= '0;
            fill_idx_r   <= '0;
            cnt_r        <= '0;
            miss_count_r <= 32'h0000_0000;
        end else if (start_fill_s) begin
            fill_tag_r   <= req_tag_s;
            fill_idx_r   <= req_idx_s;
            cnt_r        <= '0;
            miss_count_r <= miss_count_r + 32'd1;
        end else if (word_we_s && !fill_done_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Line valid bits; a line is invalidated as soon as its refill begins.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_r <= '0;
        end else if (flush_all_s) begin
            valid_r <= '0;
        end else if (start_fill_s) begin
            valid_r[req_idx_s] <= 1'b0;
        end else if (fill_done_s) begin
            valid_r[fill_idx_r] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data storage; contents are qualified by valid_r so no reset needed.
    always_ff @(posedge CLK) begin
        if (word_we_s) begin
            data_mem_r[data_ptr(fill_idx_r, cnt_r)] <= iload;
        end
        if (fill_done_s) begin
            tag_mem_r[fill_idx_r] <= fill_tag_r;
        end
    end

endmodule

// File: tb/tb_icache_param.sv
// Directed bench for icache_param (NSETS=16, BLOCK_WORDS=2) with a line-level
// reference model checked every cycle plus literal expectations.
module tb_icache_param;

    localparam int NSETS = 16;
    localparam int BW    = 2;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic        iflush = 1'b0;
    logic        iwait = 1'b0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic [31:0] miss_count;

    int vectors = 0;
    int miscompares = 0;

    // Backing memory contents: word at byte address a.
    function automatic logic [31:0] memval(input logic [31:0] a);
        logic [15:0] w;
        w = a[17:2];
        return {16'hAAAA, w - 16'h000F};
    endfunction

    assign iload = memval(iaddr);

    icache_param #(.NSETS(NSETS), .BLOCK_WORDS(BW)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .iflush(iflush), .iREN(iREN),
        .iaddr(iaddr), .iload(iload), .iwait(iwait), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge CLK);
    endtask

    // Reference model: cache contents by line address, plus an in-progress fill.
    bit          m_valid [NSETS];
    logic [31:0] m_line  [NSETS];
    logic [31:0] m_data  [NSETS][BW];
    bit          f_busy = 1'b0;
    logic [31:0] f_line = 32'h0;
    int          f_cnt = 0;
    logic [31:0] m_miss = 32'h0;
    bit          e_hit, e_ren;
    logic [31:0] e_load, e_iaddr, r_line;
    int          r_idx;

    always @(negedge CLK) begin : compare
        e_hit = 1'b0; e_ren = 1'b0; e_load = 32'h0; e_iaddr = 32'h0;
        r_line = imemaddr >> 3;
        r_idx  = int'(r_line % NSETS);
        if (!nRST) begin
            for (int i = 0; i < NSETS; i++) m_valid[i] = 1'b0;
            f_busy = 1'b0; f_cnt = 0; m_miss = 32'h0;
        end else if (!f_busy) begin
            e_hit  = imemREN && m_valid[r_idx] && (m_line[r_idx] == r_line) && !iflush;
            e_load = e_hit ? m_data[r_idx][(imemaddr >> 2) % BW] : 32'h0;
        end else begin
            e_ren   = 1'b1;
            e_iaddr = (f_line << 3) + 32'(f_cnt * 4);
        end
        check("model_ihit", 32'(ihit), 32'(e_hit));
        check("model_imemload", imemload, e_load);
        check("model_iREN", 32'(iREN), 32'(e_ren));
        check("model_iaddr", iaddr, e_iaddr);
        check("model_miss_count", miss_count, m_miss);
        if (nRST) begin
            if (!f_busy) begin
                if (iflush) begin
                    for (int i = 0; i < NSETS; i++) m_valid[i] = 1'b0;
                end else if (imemREN && !e_hit) begin
                    f_busy = 1'b1; f_line = r_line; f_cnt = 0;
                    m_miss = m_miss + 32'd1;
                    m_valid[r_idx] = 1'b0;
                end
            end else if (iflush) begin
                for (int i = 0; i < NSETS; i++) m_valid[i] = 1'b0;
                f_busy = 1'b0;
            end else if (!iwait) begin
                m_data[f_line % NSETS][f_cnt] = memval(e_iaddr);
                if (f_cnt == BW - 1) begin
                    m_line[f_line % NSETS]  = f_line;
                    m_valid[f_line % NSETS] = 1'b1;
                    f_busy = 1'b0;
                end else begin
                    f_cnt++;
                end
            end
        end
    end

    // Request a line and let an uninterrupted fill complete.
    task automatic fill(input logic [31:0] a);
        imemaddr = a; imemREN = 1'b1;
        at_neg(); tick();
        repeat (BW) begin at_neg(); tick(); end
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;

        // Reset asserted mid-fill with counter = 1.
        imemREN = 1'b1; imemaddr = 32'h40;
        at_neg(); check("rst_c0_ihit", 32'(ihit), 32'd0); tick();
        at_neg(); tick();
        nRST = 1'b0;
        at_neg();
        check("rst_mid_iREN", 32'(iREN), 32'd0);
        check("rst_mid_ihit", 32'(ihit), 32'd0);
        check("rst_mid_miss", miss_count, 32'd0);
        tick();
        nRST = 1'b1;
        at_neg(); check("refetch_miss", 32'(ihit), 32'd0); tick();

        // Cold miss timing and data.
        at_neg(); check("cold_c1_iREN", 32'(iREN), 32'd1); check("cold_c1_iaddr", iaddr, 32'h40); tick();
        at_neg(); check("cold_c2_iaddr", iaddr, 32'h44); tick();
        at_neg();
        check("cold_c3_ihit", 32'(ihit), 32'd1);
        check("cold_c3_load", imemload, 32'hAAAA0001);
        check("cold_c3_miss", miss_count, 32'd1);
        tick();
        imemaddr = 32'h44;
        at_neg(); check("cold_w1_ihit", 32'(ihit), 32'd1); check("cold_w1_load", imemload, 32'hAAAA0002); tick();

        // Arbiter stalls the first word for three cycles.
        imemREN = 1'b0; iflush = 1'b1;
        at_neg(); tick();
        iflush = 1'b0; imemREN = 1'b1; imemaddr = 32'h40;
        at_neg(); check("wait_c0_ihit", 32'(ihit), 32'd0); tick();
        iwait = 1'b1;
        repeat (3) begin at_neg(); check("wait_stall_iaddr", iaddr, 32'h40); tick(); end
        iwait = 1'b0;
        at_neg(); check("wait_c4_iaddr", iaddr, 32'h40); tick();
        at_neg(); check("wait_c5_iaddr", iaddr, 32'h44); tick();
        at_neg();
        check("wait_c6_ihit", 32'(ihit), 32'd1);
        check("wait_c6_load", imemload, 32'hAAAA0001);
        check("wait_c6_miss", miss_count, 32'd2);
        tick();

        // Conflict miss on index 8.
        nRST = 1'b0;
        at_neg(); tick();
        nRST = 1'b1;
        fill(32'h40);
        fill(32'hC0);
        imemaddr = 32'hC0;
        at_neg(); check("conf_c0_ihit", 32'(ihit), 32'd1); check("conf_c0_load", imemload, 32'hAAAA0021); tick();
        imemaddr = 32'h40;
        at_neg(); check("conf_40_ihit", 32'(ihit), 32'd0); tick();
        repeat (BW) begin at_neg(); tick(); end
        at_neg(); check("conf_miss3", miss_count, 32'd3); check("conf_40_rehit", 32'(ihit), 32'd1); tick();

        // Flush with two lines resident, then flush during the second fill word.
        fill(32'h80);
        imemaddr = 32'h80;
        at_neg(); check("fl_80_hit", 32'(ihit), 32'd1); check("fl_80_load", imemload, 32'hAAAA0011); tick();
        imemREN = 1'b0; iflush = 1'b1;
        at_neg(); tick();
        iflush = 1'b0; imemREN = 1'b1; imemaddr = 32'h40;
        at_neg(); check("fl_40_miss", 32'(ihit), 32'd0); tick();
        repeat (BW) begin at_neg(); tick(); end
        imemaddr = 32'h80;
        at_neg(); check("fl_80_miss", 32'(ihit), 32'd0); tick();
        at_neg(); tick();
        iflush = 1'b1;
        at_neg(); check("fl_abort_iREN", 32'(iREN), 32'd1); check("fl_abort_iaddr", iaddr, 32'h84); tick();
        iflush = 1'b0; imemREN = 1'b0;
        at_neg(); check("fl_after_iREN", 32'(iREN), 32'd0); tick();
        imemREN = 1'b1;
        at_neg(); check("fl_aborted_nohit", 32'(ihit), 32'd0); tick();
        repeat (BW) begin at_neg(); tick(); end
        at_neg(); check("fl_80_refill", imemload, 32'hAAAA0011); check("fl_miss7", miss_count, 32'd7); tick();

        // Branch away mid-fill: the latched line still completes.
        imemREN = 1'b0; iflush = 1'b1;
        at_neg(); tick();
        iflush = 1'b0; imemREN = 1'b1; imemaddr = 32'h40;
        at_neg(); tick();
        imemaddr = 32'h200;
        at_neg(); check("br_c1_iaddr", iaddr, 32'h40); tick();
        at_neg(); check("br_c2_iaddr", iaddr, 32'h44); tick();
        at_neg(); check("br_idle_ihit", 32'(ihit), 32'd0); check("br_idle_iREN", 32'(iREN), 32'd0); tick();
        at_neg(); check("br_200_iaddr", iaddr, 32'h200); tick();
        at_neg(); tick();
        at_neg(); check("br_200_load", imemload, 32'hAAAA0071); tick();
        imemaddr = 32'h40;
        at_neg();
        check("br_40_hit", 32'(ihit), 32'd1);
        check("br_40_load", imemload, 32'hAAAA0001);
        check("br_miss9", miss_count, 32'd9);
        tick();
        imemREN = 1'b0;
        at_neg(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
